// File: rtl/execute_stage.sv
// execute_stage: EX/MEM boundary with single-cycle ADD/SUB/AND and iterative shift-add MUL.
module execute_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic [1:0]        alufuncE,
  input  logic [DATA_W-1:0] srcdataE1,
  input  logic [DATA_W-1:0] srcdataE2,
  input  logic [ADDR_W-1:0] destaddE,
  output logic              stallE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic [DATA_W-1:0] aluresultM,
  output logic [DATA_W-1:0] writedataM,
  output logic [ADDR_W-1:0] destaddM,
  output logic              zeroM,
  output logic              carryM
);
  localparam int CW = $clog2(DATA_W);
  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;
  logic              state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic              rw_q, rw_d, mw_q, mw_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic              rwm_q, rwm_d, mwm_q, mwm_d, zero_q, zero_d, carry_q, carry_d;
  logic [DATA_W-1:0] res_q, res_d, wdm_q, wdm_d;
  logic [ADDR_W-1:0] dstm_q, dstm_d;
  logic              valid, start, busy, done, pass;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] diff, alu_r, acc_nx;
  logic              alu_c;
  assign valid  = RegWriteE | MemWriteE;
  assign busy   = state_q == BUSY;
  assign start  = !busy && valid && alufuncE == 2'b11;
  assign done   = busy && cnt_q == CW'(DATA_W - 1);
  assign pass   = !busy && !start;
  assign stallE = !reset && (start || (busy && !done));
  assign sum    = {1'b0, srcdataE1} + {1'b0, srcdataE2};
  assign diff   = srcdataE1 - srcdataE2;
  assign acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);
  // a MUL opcode reaching this path is always a bubble, so it yields zero
  always_comb begin
    alu_r = alufuncE == 2'b00 ? sum[DATA_W-1:0] :
            alufuncE == 2'b01 ? diff :
            alufuncE == 2'b10 ? (srcdataE1 & srcdataE2) : '0;
    alu_c = alufuncE == 2'b00 ? sum[DATA_W] :
            alufuncE == 2'b01 ? (srcdataE1 < srcdataE2) : 1'b0;
  end
  always_comb begin
    state_d  = start ? BUSY : done ? IDLE : state_q;
    cnt_d    = start ? '0 : busy ? cnt_q + CW'(1) : cnt_q;
    mcand_d  = start ? srcdataE1 : busy ? mcand_q << 1 : mcand_q;
    mplier_d = start ? srcdataE2 : busy ? mplier_q >> 1 : mplier_q;
    acc_d    = start ? '0 : busy ? acc_nx : acc_q;
    rw_d     = start ? RegWriteE : rw_q;
    mw_d     = start ? MemWriteE : mw_q;
    wd_d     = start ? srcdataE2 : wd_q;
    dst_d    = start ? destaddE : dst_q;
    rwm_d    = done ? rw_q : pass & RegWriteE;
    mwm_d    = done ? mw_q : pass & MemWriteE;
    res_d    = done ? acc_nx : pass ? alu_r : '0;
    wdm_d    = done ? wd_q : pass ? srcdataE2 : '0;
    dstm_d   = done ? dst_q : pass ? destaddE : '0;
    zero_d   = done ? acc_nx == '0 : pass & (alu_r == '0);
    carry_d  = pass & alu_c;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      rw_q     <= 1'b0;
      mw_q     <= 1'b0;
      wd_q     <= '0;
      dst_q    <= '0;
      rwm_q    <= 1'b0;
      mwm_q    <= 1'b0;
      res_q    <= '0;
      wdm_q    <= '0;
      dstm_q   <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      rw_q     <= rw_d;
      mw_q     <= mw_d;
      wd_q     <= wd_d;
      dst_q    <= dst_d;
      rwm_q    <= rwm_d;
      mwm_q    <= mwm_d;
      res_q    <= res_d;
      wdm_q    <= wdm_d;
      dstm_q   <= dstm_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
    end
  end
  assign RegWriteM  = rwm_q;
  assign MemWriteM  = mwm_q;
  assign aluresultM = res_q;
  assign writedataM = wdm_q;
  assign destaddM   = dstm_q;
  assign zeroM      = zero_q;
  assign carryM     = carry_q;
endmodule
